// File: rtl/result_writeback_ctrl.sv
// rtl/result_writeback_ctrl.sv - result row drain FIFO and tile writer into the result SRAM
//
// Purpose:
//   Accepts deskewed result rows over a valid/ready handshake, buffers them in a
//   small FIFO and writes one tile (MATRIX_SIZE rows) into the result SRAM at
//   consecutive addresses from a latched base address. A host read request
//   takes the SRAM port for that cycle, so no write is issued.
//
// Configuration macro:
//   RESULT_RELU_EN - when defined, each lane of the popped row is clamped to 0
//                    if negative before it is registered into sram_data.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-high reset
//   start        pulse, arms one tile write (sampled in IDLE only)
//   base_addr    first SRAM row address, latched on accepted start
//   in_valid     in_data holds a valid row
//   in_ready     block can accept a row this cycle
//   in_data      result row, lane0 in the LSBs
//   host_rd_req  host owns the SRAM port this cycle
//   sram_we      result SRAM write enable (registered)
//   sram_addr    result SRAM address (registered)
//   sram_data    result SRAM write data (registered)
//   busy         high while a tile is active
//   tile_done    one-cycle pulse after the last row of a tile is written
module result_writeback_ctrl #(
   parameter int ADDRESSSIZE    = 10,
   parameter int MATRIX_SIZE    = 16,
   parameter int PARTIAL_SUM_BW = 24,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    start,
   input  logic [ADDRESSSIZE-1:0]                  base_addr,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0]   in_data,
   input  logic                                    host_rd_req,
   output logic                                    sram_we,
   output logic [ADDRESSSIZE-1:0]                  sram_addr,
   output logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0]   sram_data,
   output logic                                    busy,
   output logic                                    tile_done
);

   localparam int RW = MATRIX_SIZE * PARTIAL_SUM_BW;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(MATRIX_SIZE + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVE,
      S_DONE
   } state_t;

   state_t                 r_state;
   logic [ADDRESSSIZE-1:0] r_base;
   logic [CW-1:0]          r_acc_cnt;
   logic [CW-1:0]          r_wr_cnt;
   logic [RW-1:0]          r_fifo [FIFO_DEPTH];
   logic [PW-1:0]          r_wptr;
   logic [PW-1:0]          r_rptr;
   logic [PW:0]            r_count;

   logic                   w_full;
   logic                   w_empty;
   logic                   w_push;
   logic                   w_pop;
   logic [RW-1:0]          w_head;
   logic [RW-1:0]          w_wdata;

   assign w_full  = (r_count == (PW+1)'(FIFO_DEPTH));
   assign w_empty = (r_count == '0);

   // in_ready depends only on registered state, never on host_rd_req: a pop
   // frees its slot for the following cycle through r_count.
   assign in_ready = (r_state == S_ACTIVE) && !w_full && (r_acc_cnt < CW'(MATRIX_SIZE));
   assign w_push   = in_valid && in_ready;
   assign w_pop    = (r_state == S_ACTIVE) && !w_empty && !host_rd_req;

   assign w_head = r_fifo[r_rptr];

   always_comb begin
      w_wdata = w_head;
`ifdef RESULT_RELU_EN
      for (int i = 0; i < MATRIX_SIZE; i++) begin
         if (w_head[i*PARTIAL_SUM_BW + PARTIAL_SUM_BW - 1]) begin
            w_wdata[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = '0;
         end
      end
`endif
   end

   // Row storage carries no reset; occupancy is tracked by the pointers/count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wptr] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_base    <= '0;
         r_acc_cnt <= '0;
         r_wr_cnt  <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         sram_we   <= 1'b0;
         sram_addr <= '0;
         sram_data <= '0;
         busy      <= 1'b0;
         tile_done <= 1'b0;
      end else begin
         sram_we   <= 1'b0;
         tile_done <= 1'b0;

         if (w_push) begin
            r_wptr    <= r_wptr + PW'(1);
            r_acc_cnt <= r_acc_cnt + CW'(1);
         end

         if (w_pop) begin
            r_rptr    <= r_rptr + PW'(1);
            r_wr_cnt  <= r_wr_cnt + CW'(1);
            sram_we   <= 1'b1;
            // Address wraps naturally at 2^ADDRESSSIZE.
            sram_addr <= r_base + ADDRESSSIZE'(r_wr_cnt);
            sram_data <= w_wdata;
         end

         if (w_push && !w_pop) begin
            r_count <= r_count + (PW+1)'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - (PW+1)'(1);
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state   <= S_ACTIVE;
                  busy      <= 1'b1;
                  r_base    <= base_addr;
                  r_acc_cnt <= '0;
                  r_wr_cnt  <= '0;
               end
            end
            S_ACTIVE: begin
               // wr_cnt reaches MATRIX_SIZE on the edge that issues the last
               // write, so tile_done follows that write by one cycle.
               if (r_wr_cnt == CW'(MATRIX_SIZE)) begin
                  r_state   <= S_DONE;
                  busy      <= 1'b0;
                  tile_done <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
